// File: rtl/cnn_pkg.sv
// cnn_pkg: shared types for the CNN max-pool / sliding-window stage.
// Holds the sample type, window tap indexing and the window FSM states.
package cnn_pkg;

    localparam int CNN_DW = 18;

    typedef logic signed [CNN_DW-1:0] sample_t;

    typedef enum logic {
        RUN  = 1'b0,
        DONE = 1'b1
    } win_state_e;

    // Flat tap position of (channel, row, col) inside a window bundle
    function automatic int tap_idx(input int c, input int r,
                                   input int q, input int k);
        return (c * k + r) * k + q;
    endfunction

endpackage

// File: rtl/pool_win_ram.sv
// pool_win_ram: one channel of pooled-map storage.
// Single write port, KxK combinational taps around a top-left base address.
module pool_win_ram
    import cnn_pkg::*;
#(
    parameter int DW    = 18,
    parameter int IMG_W = 13,
    parameter int N     = 169,
    parameter int K     = 3,
    parameter int AW    = $clog2(N + 1)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DW-1:0]     i_wdata,
    input  logic [AW-1:0]     i_base,
    output logic [K*K*DW-1:0] o_taps
);

    logic [DW-1:0] r_mem [N];

    // Raster-order write of one pooled sample; contents are never reset
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    for (genvar r = 0; r < K; r++) begin : g_row
        for (genvar q = 0; q < K; q++) begin : g_col
            localparam int OFF = r * IMG_W + q;
            logic [AW-1:0] w_addr;
            assign w_addr = i_base + AW'(OFF);
            assign o_taps[tap_idx(0, r, q, K)*DW +: DW] = r_mem[w_addr];
        end
    end

endmodule

// File: rtl/pool_window_buf.sv
// pool_window_buf: 2x2 signed max-pool, per-channel frame buffer, KxK window emitter.
// Build option POOL_RELU_EN clamps negative pooled values to zero before storage.
module pool_window_buf
    import cnn_pkg::*;
#(
    parameter int DW    = 18,
    parameter int CH    = 2,
    parameter int IMG_W = 13,
    parameter int IMG_H = 13,
    parameter int K     = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CH*4*DW-1:0]   din,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CH*K*K*DW-1:0] dout,
    output logic                 frame_done
);

    localparam int N  = IMG_W * IMG_H;
    localparam int AW = $clog2(N + 1);
    localparam int TW = K * K * DW;

    localparam logic [AW-1:0] L_N     = AW'(N);
    localparam logic [AW-1:0] L_W     = AW'(IMG_W);
    localparam logic [AW-1:0] L_KM1   = AW'(K - 1);
    localparam logic [AW-1:0] L_LASTR = AW'(IMG_H - K);
    localparam logic [AW-1:0] L_LASTC = AW'(IMG_W - K);
    localparam logic [AW-1:0] L_ONE   = AW'(1);

    win_state_e          r_state;
    win_state_e          w_state_nxt;
    logic [AW-1:0]       r_wr_cnt;
    logic [AW-1:0]       r_rd_row;
    logic [AW-1:0]       r_rd_col;
    logic                r_out_valid;
    logic                r_frame_done;
    logic [CH*TW-1:0]    r_dout;
    logic [CH*TW-1:0]    w_taps;
    logic [AW-1:0]       w_base;
    logic [AW-1:0]       w_br;
    logic                w_acc;
    logic                w_avail;
    logic                w_slot;
    logic                w_load;
    logic                w_last;
    logic                w_fd_nxt;

    assign in_ready = (r_state == RUN) && (r_wr_cnt < L_N);
    assign w_acc    = in_valid && in_ready && !clr;

    // Top-left of the current window and its bottom-right address
    assign w_base  = r_rd_row * L_W + r_rd_col;
    assign w_br    = w_base + L_KM1 * L_W + L_KM1;
    assign w_avail = (r_state == RUN) && (w_br < r_wr_cnt);
    assign w_slot  = !r_out_valid || out_ready;
    assign w_load  = w_slot && w_avail;
    assign w_last  = (r_rd_row == L_LASTR) && (r_rd_col == L_LASTC);

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic signed [DW-1:0] w_q0;
        logic signed [DW-1:0] w_q1;
        logic signed [DW-1:0] w_q2;
        logic signed [DW-1:0] w_q3;
        logic signed [DW-1:0] w_m01;
        logic signed [DW-1:0] w_m23;
        logic signed [DW-1:0] w_pmax;
        logic signed [DW-1:0] w_store;

        assign w_q0 = din[(c*4+0)*DW +: DW];
        assign w_q1 = din[(c*4+1)*DW +: DW];
        assign w_q2 = din[(c*4+2)*DW +: DW];
        assign w_q3 = din[(c*4+3)*DW +: DW];

        // Strict greater-than keeps the lower index on ties
        assign w_m01  = (w_q1 > w_q0) ? w_q1 : w_q0;
        assign w_m23  = (w_q3 > w_q2) ? w_q3 : w_q2;
        assign w_pmax = (w_m23 > w_m01) ? w_m23 : w_m01;

`ifdef POOL_RELU_EN
        assign w_store = w_pmax[DW-1] ? '0 : w_pmax;
`else
        assign w_store = w_pmax;
`endif

        pool_win_ram #(
            .DW    (DW),
            .IMG_W (IMG_W),
            .N     (N),
            .K     (K),
            .AW    (AW)
        ) u_ram (
            .clk     (clk),
            .i_we    (w_acc),
            .i_waddr (r_wr_cnt),
            .i_wdata (w_store),
            .i_base  (w_base),
            .o_taps  (w_taps[c*TW +: TW])
        );
    end

    // Next state: leave RUN once the final window is loaded; pulse done on its handshake
    always_comb begin
        w_state_nxt = r_state;
        w_fd_nxt    = 1'b0;
        unique case (r_state)
            RUN: begin
                if (w_load && w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_fd_nxt = r_out_valid && out_ready;
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    // State register; clr restarts the frame
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Write counter, read pointer and output window register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_cnt     <= '0;
            r_rd_row     <= '0;
            r_rd_col     <= '0;
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_dout       <= '0;
        end else if (clr) begin
            r_wr_cnt     <= '0;
            r_rd_row     <= '0;
            r_rd_col     <= '0;
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_fd_nxt;
            if (w_acc) begin
                r_wr_cnt <= r_wr_cnt + L_ONE;
            end
            if (w_load) begin
                r_dout      <= w_taps;
                r_out_valid <= 1'b1;
                if (r_rd_col == L_LASTC) begin
                    r_rd_col <= '0;
                    r_rd_row <= r_rd_row + L_ONE;
                end else begin
                    r_rd_col <= r_rd_col + L_ONE;
                end
            end else if (w_slot) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign dout       = r_dout;
    assign frame_done = r_frame_done;

endmodule
